// File: rtl/aes_pkg.sv
// Shared AES definitions for the byte-serial SubBytes/ShiftRows stage:
// fixed widths, the byte-array state type, the ShiftRows index map and
// the FSM state encoding.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    // Element 0 is the most significant byte, so byte i of a 128-bit state
    // vector (bits [127-8i -: 8]) is simply element i.
    typedef logic [0:AES_BYTES-1][7:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    // Destination index of source byte src_idx after ShiftRows.
    // row = idx % 4 stays put; the column rotates left by row (2-bit wrap).
    function automatic logic [3:0] shiftrows_idx(input logic [3:0] src_idx);
        logic [1:0] row;
        logic [1:0] col;
        row = src_idx[1:0];
        col = src_idx[3:2] - row;
        return {col, row};
    endfunction

endpackage

// File: rtl/aes_subshift_serial_sbox.sv
// AES forward S-box: purely combinational 256-entry lookup.
module aes_sbox (
    input  logic [7:0] unboxed_i,
    output logic [7:0] boxed_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Table lookup, no register.
    assign boxed_o = SBOX[unboxed_i];

endmodule

// File: rtl/aes_subshift_serial.sv
// Byte-serial AES SubBytes + ShiftRows. One shared S-box processes the
// 16 state bytes over 16 cycles; each result lands directly in its
// ShiftRows position of the output register.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream holds in_valid/in_state until in_ready; out_state is
// stable while out_valid is high and until out_ready completes the transfer.
module aes_subshift_serial
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    fsm_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    aes_state_t src_q, src_d;
    aes_state_t out_q, out_d;
    logic [7:0] sbox_in;
    logic [7:0] sbox_out;

    // The counter picks the source byte fed to the shared S-box.
    assign sbox_in = src_q[cnt_q];

    aes_sbox sboxinst1 (
        .unboxed_i (sbox_in),
        .boxed_o   (sbox_out)
    );

    // State registers; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            out_q   <= out_d;
        end
    end

    // Next-state, byte write and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        src_d     = src_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    src_d   = in_state;
                    cnt_d   = 4'd0;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                out_d[shiftrows_idx(cnt_q)] = sbox_out;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign out_state = out_q;

endmodule

// File: tb/tb_aes_subshift_serial.sv
// Directed bench for aes_subshift_serial: vector table plus hand-written
// sequences for backpressure, mid-operation reset and back-to-back blocks.
module tb_aes_subshift_serial;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [127:0] exp_q[$];
    int           acc_q[$];

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_OUT  = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
    localparam logic [127:0] ZERO_OUT = {16{8'h63}};

    typedef struct {
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    vec_t vecs[5];

    aes_subshift_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, want);
        end
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge, idle again.
    task automatic run_vec(input logic [127:0] din, input logic [127:0] dexp, input string nm);
        int lat;
        chk({nm, " in_ready"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_state = din;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, " latency"}, 128'(lat), 128'd16);
        chk({nm, " out_state"}, out_state, dexp);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " idle after handshake"}, 128'({in_ready, out_valid, busy}), 128'b100);
    endtask

    initial begin
        logic         bad;
        logic [127:0] held;
        logic [127:0] ins[2];
        logic [127:0] exps[2];
        int           k;
        int           n_out;

        vecs[0] = '{FIPS_IN, FIPS_OUT};
        vecs[1] = '{128'h0, ZERO_OUT};
        vecs[2] = '{SEQ_IN, SEQ_OUT};
        vecs[3] = '{{16{8'hff}}, {16{8'h16}}};
        vecs[4] = '{{16{8'h53}}, {16{8'hed}}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", 128'(in_ready), 128'd1);
        chk("reset out_valid", 128'(out_valid), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset out_state", out_state, 128'h0);

        // Vector table.
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i].din, vecs[i].dexp, $sformatf("vec%0d", i));
        end

        // Backpressure and in_valid toggling while busy.
        in_valid = 1'b1;
        in_state = FIPS_IN;
        @(posedge clk);
        @(negedge clk);
        in_state = 128'h0;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = i[0];
            if (in_ready || out_valid) bad = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp in_ready low during SUB", 128'(bad), 128'd0);
        chk("bp out_valid at DONE", 128'(out_valid), 128'd1);
        chk("bp out_state", out_state, FIPS_OUT);
        held = out_state;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~i[0];
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || in_ready || out_state !== held) bad = 1'b1;
        end
        chk("bp DONE held 10 cycles", 128'(bad), 128'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release idle", 128'({in_ready, busy, out_valid}), 128'b100);
        in_valid = 1'b1;
        in_state = 128'h0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp new accept busy", 128'({busy, in_ready}), 128'b10);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk("bp second latency", 128'(k), 128'd16);
        chk("bp second out_state", out_state, ZERO_OUT);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset with cnt at 7.
        in_valid = 1'b1;
        in_state = SEQ_IN;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midreset in_ready", 128'(in_ready), 128'd1);
        chk("midreset busy", 128'(busy), 128'd0);
        chk("midreset out_valid", 128'(out_valid), 128'd0);
        chk("midreset out_state", out_state, 128'h0);
        run_vec(FIPS_IN, FIPS_OUT, "after reset");

        // Back-to-back with in_valid and out_ready held high.
        ins[0]  = FIPS_IN;
        ins[1]  = SEQ_IN;
        exps[0] = FIPS_OUT;
        exps[1] = SEQ_OUT;
        k       = 0;
        n_out   = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = ins[0];
        for (int c = 0; c < 60 && n_out < 2; c++) begin
            if (in_valid && in_ready && k < 2) begin
                acc_q.push_back(cyc);
                exp_q.push_back(exps[k]);
                k++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("b2b unexpected output", out_state, 128'h0 ^ ~out_state);
                end else begin
                    chk($sformatf("b2b out%0d", n_out), out_state, exp_q.pop_front());
                end
            end
            @(posedge clk);
            @(negedge clk);
            if (k == 1) in_state = ins[1];
            else if (k == 2) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b output count", 128'(n_out), 128'd2);
        if (acc_q.size() == 2) begin
            chk("b2b accept spacing", 128'(acc_q[1] - acc_q[0]), 128'd18);
        end else begin
            chk("b2b accept count", 128'(acc_q.size()), 128'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
